// File: rtl/collision_score.sv
// Bird/tube/ground collision detection with a sticky lose flag and a saturating two-digit BCD score.
// Geometry is evaluated only on unpaused frame ticks while playing; restart and rst return to a fresh game.
module collision_score #(
    parameter logic [9:0] BIRD_X  = 10'd150,
    parameter logic [9:0] BIRD_W  = 10'd20,
    parameter logic [9:0] BIRD_H  = 10'd20,
    parameter logic [9:0] TUBE_W  = 10'd60,
    parameter logic [9:0] GAP_Y1  = 10'd120,
    parameter logic [9:0] GAP_Y2  = 10'd200,
    parameter logic [9:0] GAP_Y3  = 10'd80,
    parameter logic [9:0] GAP_H   = 10'd120,
    parameter logic [9:0] FLOOR_Y = 10'd460
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       pausa,
    input  logic       restart,
    input  logic [9:0] posX_tube1,
    input  logic [9:0] posX_tube2,
    input  logic [9:0] posX_tube3,
    input  logic [9:0] pos_y_bird,
    output logic       loose,
    output logic [7:0] score,
    output logic       score_pulse
);

    typedef enum logic {
        PLAY = 1'b0,
        HIT  = 1'b1
    } state_t;

    localparam logic [10:0] BIRD_L = {1'b0, BIRD_X};
    localparam logic [10:0] BIRD_R = {1'b0, BIRD_X} + {1'b0, BIRD_W};

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_passed;
    logic [7:0]  r_score;
    logic        r_score_pulse;

    logic [9:0]  w_pos_x [3];
    logic [10:0] w_bird_bot;
    logic [2:0]  w_tube_hit;
    logic [2:0]  w_set;
    logic [2:0]  w_clr;
    logic [2:0]  w_new_pass;
    logic        w_ground_hit;
    logic        w_hit;
    logic        w_eval;
    logic [1:0]  w_pass_cnt;
    logic [4:0]  w_units_sum;
    logic        w_carry;
    logic [3:0]  w_units_adj;
    logic [4:0]  w_tens_sum;
    logic [7:0]  w_score_inc;

    assign w_pos_x[0] = posX_tube1;
    assign w_pos_x[1] = posX_tube2;
    assign w_pos_x[2] = posX_tube3;

    // All edge sums are 11 bits wide so a tube near column 1023 never wraps.
    assign w_bird_bot = {1'b0, pos_y_bird} + {1'b0, BIRD_H};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tube
            localparam logic [9:0] GY = (gi == 0) ? GAP_Y1 : (gi == 1) ? GAP_Y2 : GAP_Y3;
            localparam logic [10:0] GAP_BOT = {1'b0, GY} + {1'b0, GAP_H};
            logic [10:0] w_tube_r;
            logic        w_overlap;

            assign w_tube_r  = {1'b0, w_pos_x[gi]} + {1'b0, TUBE_W};
            assign w_overlap = ({1'b0, w_pos_x[gi]} < BIRD_R) && (w_tube_r > BIRD_L);
            assign w_tube_hit[gi] = w_overlap && ((pos_y_bird < GY) || (w_bird_bot > GAP_BOT));
            assign w_set[gi] = (w_tube_r <= BIRD_L);
            assign w_clr[gi] = ({1'b0, w_pos_x[gi]} >= BIRD_R);
        end
    endgenerate

    assign w_ground_hit = (w_bird_bot > {1'b0, FLOOR_Y});
    assign w_hit        = (|w_tube_hit) || w_ground_hit;
    assign w_eval       = tick && !pausa && (r_state == PLAY) && !restart;
    assign w_new_pass   = w_set & ~r_passed;
    assign w_pass_cnt   = {1'b0, w_new_pass[0]} + {1'b0, w_new_pass[1]} + {1'b0, w_new_pass[2]};

    // Digit-wise BCD add of 0..3; a tens overflow means the true sum exceeded 99.
    assign w_units_sum = {1'b0, r_score[3:0]} + {3'b000, w_pass_cnt};
    assign w_carry     = (w_units_sum > 5'd9);
    assign w_units_adj = w_carry ? (w_units_sum[3:0] - 4'd10) : w_units_sum[3:0];
    assign w_tens_sum  = {1'b0, r_score[7:4]} + {4'b0000, w_carry};
    assign w_score_inc = (w_tens_sum > 5'd9) ? 8'h99 : {w_tens_sum[3:0], w_units_adj};

    always_comb begin
        w_state_next = r_state;
        if (restart) begin
            w_state_next = PLAY;
        end else if (w_eval && w_hit) begin
            w_state_next = HIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PLAY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Passed flags track tubes even on a colliding tick; restart reloads them silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_passed <= 3'b000;
        end else if (restart) begin
            r_passed <= w_set;
        end else if (w_eval) begin
            r_passed <= w_set | (r_passed & ~w_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_score       <= 8'h00;
            r_score_pulse <= 1'b0;
        end else if (w_eval && !w_hit) begin
            r_score       <= w_score_inc;
            r_score_pulse <= (w_score_inc != r_score);
        end else begin
            r_score_pulse <= 1'b0;
        end
    end

    assign loose       = (r_state == HIT);
    assign score       = r_score;
    assign score_pulse = r_score_pulse;

endmodule

// File: tb/tb_collision_score.sv
// Scenario bench for collision_score: each task queues expected {loose, score, pulse}
// before driving a cycle and pops/compares after the clock edge.
module tb_collision_score;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       pausa;
    logic       restart;
    logic [9:0] posX_tube1;
    logic [9:0] posX_tube2;
    logic [9:0] posX_tube3;
    logic [9:0] pos_y_bird;
    logic       loose;
    logic [7:0] score;
    logic       score_pulse;

    typedef struct {
        string      name;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    collision_score dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .pausa      (pausa),
        .restart    (restart),
        .posX_tube1 (posX_tube1),
        .posX_tube2 (posX_tube2),
        .posX_tube3 (posX_tube3),
        .pos_y_bird (pos_y_bird),
        .loose      (loose),
        .score      (score),
        .score_pulse(score_pulse)
    );

    always #10 clk = ~clk;

    function automatic logic [9:0] ex(input logic l, input logic [7:0] s, input logic p);
        return {l, s, p};
    endfunction

    function automatic logic [7:0] bcd(input int n);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    // Drive-only helper: one clock edge, then sample 1 ns later and drop strobes.
    task automatic step();
        @(posedge clk);
        #1;
        tick    = 1'b0;
        restart = 1'b0;
    endtask

    task automatic set_tubes(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        posX_tube1 = a;
        posX_tube2 = b;
        posX_tube3 = c;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst = 1'b1; tick = 1'b1; pausa = 1'b0;
            set_tubes(10'd140, 10'd90, 10'd500);
            pos_y_bird = 10'd60;
            sb.push_back('{name: "reset", v: ex(1'b0, 8'h00, 1'b0)});
            step();
            e = sb.pop_front();
            vectors++;
            $display("vec %0d %s: loose=%b score=%h pulse=%b", vectors, e.name, loose, score, score_pulse);
            if ({loose, score, score_pulse} !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %b/%h/%b required %b/%h/%b", e.name, loose, score, score_pulse, e.v[9], e.v[8:1], e.v[0]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_pass();
        logic [9:0] xs [4] = '{10'd91, 10'd90, 10'd90, 10'd90};
        logic       tk [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [9:0] ev [4];
        ev[0] = ex(1'b0, 8'h00, 1'b0);
        ev[1] = ex(1'b0, 8'h01, 1'b1);
        ev[2] = ex(1'b0, 8'h01, 1'b0);
        ev[3] = ex(1'b0, 8'h01, 1'b0);
        set_tubes(10'd500, 10'd500, 10'd500);
        pos_y_bird = 10'd150;
        for (int i = 0; i < 4; i++) begin
            posX_tube1 = xs[i];
            tick = tk[i];
            sb.push_back('{name: $sformatf("pass_row%0d", i), v: ev[i]});
            step();
            e = sb.pop_front();
            vectors++;
            $display("vec %0d %s: loose=%b score=%h pulse=%b", vectors, e.name, loose, score, score_pulse);
            if ({loose, score, score_pulse} !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %b/%h/%b required %b/%h/%b", e.name, loose, score, score_pulse, e.v[9], e.v[8:1], e.v[0]);
            end
        end
    endtask

    task automatic test_bcd_carry();
        for (int k = 2; k <= 10; k++) begin
            for (int ph = 0; ph < 2; ph++) begin
                posX_tube1 = (ph == 1) ? 10'd90 : 10'd500;
                tick = 1'b1;
                if (ph == 1)
                    sb.push_back('{name: $sformatf("carry_to_%0d", k), v: ex(1'b0, bcd(k), 1'b1)});
                else
                    sb.push_back('{name: $sformatf("wrap_at_%0d", k - 1), v: ex(1'b0, bcd(k - 1), 1'b0)});
                step();
                e = sb.pop_front();
                vectors++;
                $display("vec %0d %s: loose=%b score=%h pulse=%b", vectors, e.name, loose, score, score_pulse);
                if ({loose, score, score_pulse} !== e.v) begin
                    miscompares++;
                    $display("FAIL %s: got %b/%h/%b required %b/%h/%b", e.name, loose, score, score_pulse, e.v[9], e.v[8:1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_triple_sat();
        int prev;
        int now;
        set_tubes(10'd500, 10'd500, 10'd500);
        pos_y_bird = 10'd150;
        restart = 1'b1;
        sb.push_back('{name: "triple_restart", v: ex(1'b0, 8'h00, 1'b0)});
        step();
        e = sb.pop_front();
        vectors++;
        $display("vec %0d %s: loose=%b score=%h pulse=%b", vectors, e.name, loose, score, score_pulse);
        if ({loose, score, score_pulse} !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %b/%h/%b required %b/%h/%b", e.name, loose, score, score_pulse, e.v[9], e.v[8:1], e.v[0]);
        end
        for (int k = 1; k <= 35; k++) begin
            prev = (3 * (k - 1) > 99) ? 99 : 3 * (k - 1);
            now  = (3 * k > 99) ? 99 : 3 * k;
            for (int ph = 0; ph < 2; ph++) begin
                tick = 1'b1;
                if (ph == 0) begin
                    set_tubes(10'd500, 10'd500, 10'd500);
                    sb.push_back('{name: $sformatf("triple_wrap%0d", k), v: ex(1'b0, bcd(prev), 1'b0)});
                end else begin
                    // final iteration passes only tube1 to check single-pass saturation
                    if (k == 35) set_tubes(10'd90, 10'd500, 10'd500);
                    else         set_tubes(10'd90, 10'd90, 10'd90);
                    sb.push_back('{name: $sformatf("triple_pass%0d", k), v: ex(1'b0, bcd(now), (now != prev) ? 1'b1 : 1'b0)});
                end
                step();
                e = sb.pop_front();
                vectors++;
                $display("vec %0d %s: loose=%b score=%h pulse=%b", vectors, e.name, loose, score, score_pulse);
                if ({loose, score, score_pulse} !== e.v) begin
                    miscompares++;
                    $display("FAIL %s: got %b/%h/%b required %b/%h/%b", e.name, loose, score, score_pulse, e.v[9], e.v[8:1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_ground();
        logic [9:0] ys [6] = '{10'd150, 10'd440, 10'd0, 10'd445, 10'd445, 10'd150};
        logic       rs [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       ps [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       lo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        set_tubes(10'd500, 10'd500, 10'd500);
        for (int i = 0; i < 6; i++) begin
            pos_y_bird = ys[i];
            restart = rs[i];
            pausa = ps[i];
            tick = 1'b1;
            sb.push_back('{name: $sformatf("ground_row%0d", i), v: ex(lo[i], 8'h00, 1'b0)});
            step();
            e = sb.pop_front();
            vectors++;
            $display("vec %0d %s: loose=%b score=%h pulse=%b", vectors, e.name, loose, score, score_pulse);
            if ({loose, score, score_pulse} !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %b/%h/%b required %b/%h/%b", e.name, loose, score, score_pulse, e.v[9], e.v[8:1], e.v[0]);
            end
        end
        pausa = 1'b0;
    endtask

    task automatic test_restart_hit();
        logic [9:0] x1 [6];
        logic [9:0] x2 [6];
        logic [9:0] yy [6];
        logic       rs [6];
        logic [9:0] ev [6];
        x1 = '{10'd500, 10'd140, 10'd90, 10'd90, 10'd90, 10'd500};
        x2 = '{10'd500, 10'd90, 10'd500, 10'd90, 10'd90, 10'd500};
        yy = '{10'd150, 10'd60, 10'd150, 10'd150, 10'd150, 10'd150};
        rs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ev[0] = ex(1'b0, 8'h07, 1'b0);
        ev[1] = ex(1'b1, 8'h07, 1'b0);
        ev[2] = ex(1'b1, 8'h07, 1'b0);
        ev[3] = ex(1'b0, 8'h00, 1'b0);
        ev[4] = ex(1'b0, 8'h00, 1'b0);
        ev[5] = ex(1'b0, 8'h00, 1'b0);
        set_tubes(10'd500, 10'd500, 10'd500);
        pos_y_bird = 10'd150;
        restart = 1'b1;
        step();
        for (int k = 0; k < 7; k++) begin
            posX_tube1 = 10'd500; tick = 1'b1; step();
            posX_tube1 = 10'd90;  tick = 1'b1; step();
        end
        for (int i = 0; i < 6; i++) begin
            posX_tube1 = x1[i];
            posX_tube2 = x2[i];
            pos_y_bird = yy[i];
            restart = rs[i];
            tick = 1'b1;
            sb.push_back('{name: $sformatf("hit_row%0d", i), v: ev[i]});
            step();
            e = sb.pop_front();
            vectors++;
            $display("vec %0d %s: loose=%b score=%h pulse=%b", vectors, e.name, loose, score, score_pulse);
            if ({loose, score, score_pulse} !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %b/%h/%b required %b/%h/%b", e.name, loose, score, score_pulse, e.v[9], e.v[8:1], e.v[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_tubes(10'd500, 10'd500, 10'd500);
        pos_y_bird = 10'd150;
        restart = 1'b1;
        step();
        for (int k = 0; k < 14; k++) begin
            set_tubes(10'd500, 10'd500, 10'd500); tick = 1'b1; step();
            set_tubes(10'd90, 10'd90, 10'd90);    tick = 1'b1; step();
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                posX_tube1 = 10'd140; pos_y_bird = 10'd60; tick = 1'b1;
                sb.push_back('{name: "mid_hit", v: ex(1'b1, 8'h42, 1'b0)});
            end else if (i == 1) begin
                rst = 1'b1; tick = 1'b1;
                sb.push_back('{name: "mid_reset", v: ex(1'b0, 8'h00, 1'b0)});
            end else begin
                rst = 1'b0; tick = 1'b1;
                set_tubes(10'd90, 10'd500, 10'd500); pos_y_bird = 10'd150;
                sb.push_back('{name: "post_reset_pass", v: ex(1'b0, 8'h01, 1'b1)});
            end
            step();
            e = sb.pop_front();
            vectors++;
            $display("vec %0d %s: loose=%b score=%h pulse=%b", vectors, e.name, loose, score, score_pulse);
            if ({loose, score, score_pulse} !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %b/%h/%b required %b/%h/%b", e.name, loose, score, score_pulse, e.v[9], e.v[8:1], e.v[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; pausa = 1'b0; restart = 1'b0;
        posX_tube1 = 10'd500; posX_tube2 = 10'd500; posX_tube3 = 10'd500;
        pos_y_bird = 10'd150;
        test_reset();
        test_pass();
        test_bcd_carry();
        test_triple_sat();
        test_ground();
        test_restart_hit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/collision_score.md
COLLISION_SCORE -- requirements
Module: collision_score

Interface
REQ-001 SHALL have parameter BIRD_X, default 10'd150, meaning bird left edge in pixels (fixed column).
REQ-002 SHALL have parameter BIRD_W, default 10'd20, meaning bird width; BIRD_H, default 10'd20, meaning bird height.
REQ-003 SHALL have parameter TUBE_W, default 10'd60, meaning tube width in pixels.
REQ-004 SHALL have parameters GAP_Y1/GAP_Y2/GAP_Y3, defaults 10'd120/10'd200/10'd80, meaning gap top row of tubes 1..3; GAP_H, default 10'd120, meaning gap height.
REQ-005 SHALL have parameter FLOOR_Y, default 10'd460, meaning first row counted as ground.
REQ-006 SHALL have port clk  input  1  system clock, 50 MHz, sole clock.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port tick  input  1  one-cycle frame-step strobe (horizontal counter time_out).
REQ-009 SHALL have port pausa  input  1  game-paused level.
REQ-010 SHALL have port restart  input  1  one-cycle strobe (debounced jump one-shot).
REQ-011 SHALL have ports posX_tube1/2/3  input  10 each  tube left-edge columns.
REQ-012 SHALL have port pos_y_bird  input  10  bird top row.
REQ-013 SHALL have port loose  output  1  sticky collision flag, to state FSM and color decoder.
REQ-014 SHALL have port score  output  8  two-digit BCD score, [7:4] tens, [3:0] units.
REQ-015 SHALL have port score_pulse  output  1  one-cycle strobe on each score increment.

Function
REQ-016 SHALL evaluate geometry only on cycles with tick=1, pausa=0, state PLAY; all other cycles hold outputs (score_pulse=0).
REQ-017 SHALL compute all edge sums (posX+TUBE_W, pos_y_bird+BIRD_H, GAP_Y+GAP_H) at 11 bits; no 10-bit wrap permitted.
REQ-018 SHALL define horizontal overlap for tube n: posX_tube_n < BIRD_X+BIRD_W AND posX_tube_n+TUBE_W > BIRD_X.
REQ-019 SHALL define tube hit n: overlap n AND (pos_y_bird < GAP_Yn OR pos_y_bird+BIRD_H > GAP_Yn+GAP_H).
REQ-020 SHALL define ground hit: pos_y_bird+BIRD_H > FLOOR_Y; ceiling (pos_y_bird=0) is not a hit.
REQ-021 SHALL implement FSM states PLAY and HIT; PLAY->HIT on evaluated cycle with any tube hit or ground hit; HIT->PLAY on restart=1.
REQ-022 SHALL drive loose=1 exactly when state is HIT, registered, asserting the cycle after the evaluating tick.
REQ-023 SHALL keep per-tube passed flag: set when posX_tube_n+TUBE_W <= BIRD_X; cleared when posX_tube_n >= BIRD_X+BIRD_W (tube wrapped to right).
REQ-024 SHALL increment score by one per tube whose passed flag transitions 0->1 on an evaluated cycle; two or three simultaneous transitions add 2 or 3.
REQ-025 SHALL perform BCD arithmetic: units 9 carries to tens; score saturates at 8'h99.
REQ-026 SHALL give collision priority: evaluated cycle with any hit sets HIT and adds no score, passed flags still update.
REQ-027 SHALL pulse score_pulse for one cycle, the cycle score changes; none when saturated at 99.
REQ-028 SHALL on restart (any state) clear score to 8'h00, loose to 0, state to PLAY, and reload passed flags from current positions without scoring.
REQ-029 SHALL ignore tick on the same cycle as restart; restart wins.

Reset
REQ-030 SHALL on rst=1 at a clk edge force state PLAY, loose=0, score=8'h00, score_pulse=0, all passed flags=0, regardless of other inputs.
REQ-031 SHALL apply reset mid-operation identically; first evaluation is the first qualifying tick after rst deasserts.

Verification
REQ-032 SHALL cover: tube1 X=140, bird Y=60, GAP_Y1=120, tick -> loose=1 next cycle, score unchanged.
REQ-033 SHALL cover: tube1 X moves 91->90 (90+60=150) with bird in gap, tick -> score 00->01, score_pulse one cycle.
REQ-034 SHALL cover: score 8'h09 plus one pass -> 8'h10; score 8'h99 plus pass -> stays 8'h99, no pulse.
REQ-035 SHALL cover: pos_y_bird=445 (445+20>460), tick with pausa=1 -> loose stays 0; pausa=0 tick -> loose=1.
REQ-036 SHALL cover: state HIT, score 8'h07, restart=1 with tick=1 -> next cycle loose=0, score=8'h00, no pulse.
REQ-037 SHALL cover: rst=1 mid-game with loose=1, score 8'h42 -> next cycle loose=0, score=8'h00.
